ysyx_22050058_ifu_resp: RTL and testbench
=========================================

# ysyx_22050058_ifu_resp

Instruction-fetch responder for the ysyx_22050058 core. Consumes the PC/chip-enable pair issued by the PC register, runs one outstanding read per fetch against instruction memory with a req/ack handshake, and presents the fetched instruction with its PC to the ID stage. While a fetch is pending it raises a stall request to the CtrlBlock. Jumps flush in-flight fetches.

## Interface
- ADDR_W, 64, PC/address width (`ysyx_22050058_InstAdderBus` width)
- INST_W, 32, instruction width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pc_i  in  ADDR_W  fetch address from PC register
- ce_i  in  1  chip enable from PC register; 0 = no fetch
- flush_i  in  1  jump taken (isjump) this cycle; kill current fetch/output
- stall_i  in  6  CtrlBlock stall vector; stall_i[1] holds the ID stage
- mem_req_o  out  1  read request, held until ack
- mem_addr_o  out  ADDR_W  word-aligned read address, stable while mem_req_o
- mem_ack_i  in  1  read data valid this cycle
- mem_rdata_i  in  INST_W  read data
- inst_o  out  INST_W  instruction to ID
- inst_pc_o  out  ADDR_W  PC of inst_o
- inst_valid_o  out  1  inst_o/inst_pc_o valid
- inst_misalign_o  out  1  inst_pc_o had pc[1:0] != 0
- stallreq_o  out  1  stall request to CtrlBlock (combinational)

## Operation
- FSM states: IDLE, REQ, HOLD. Reset: IDLE; all registered outputs 0 (mem_req_o, mem_addr_o, inst_o, inst_pc_o, inst_valid_o, inst_misalign_o); drop flag 0.
- IDLE: if ce_i=1, flush_i=0, stall_i[0]=0 → latch pc_i into addr/pc regs, mem_addr_o = {pc_i[ADDR_W-1:2],2'b00}, misalign bit = |pc_i[1:0], mem_req_o<=1, go REQ. Otherwise stay; inst_valid_o<=0.
- REQ: mem_req_o and mem_addr_o held. flush_i=1 sets drop flag. On mem_ack_i: mem_req_o<=0; if drop flag or flush_i this cycle → discard data, clear drop, inst_valid_o<=0, go IDLE; else capture inst_o<=mem_rdata_i, inst_pc_o, inst_misalign_o, inst_valid_o<=1, go HOLD.
- HOLD: outputs frozen while stall_i[1]=1. flush_i=1 → inst_valid_o<=0, go IDLE (flush wins over stall). stall_i[1]=0 → ID consumes this cycle; apply IDLE acceptance logic in the same cycle (back-to-back fetch); if no new fetch, inst_valid_o<=0 and go IDLE.
- stallreq_o = (state==REQ) & ~mem_ack_i.
- Misaligned pc is fetched at the aligned address and flagged; no exception handling here.
- mem_ack_i outside REQ is ignored.

## Timing
- Accept in cycle N → mem_req_o high N+1. Ack in cycle M (M ≥ N+1) → inst_valid_o high M+1. Zero-wait memory (ack in N+1): one instruction per 2 cycles minimum; HOLD→REQ handoff gives 1 request per ack+1 cycle.
- inst_valid_o pulses exactly one cycle per fetch unless stall_i[1] extends it.
- flush_i in the same cycle as ack: data dropped, no valid. flush_i in IDLE with ce_i=1: no request issued.
- rst mid-REQ: request dropped next edge; outstanding ack after reset is ignored (state IDLE).

## Structure
- FSM state encodings and the ID-stall index (1) go in ysyx_22050058_define.v alongside existing ChipEnable/StallEnable/IsJump macros; use those macros for ce_i/flush_i/stall compares.
- Single flat module; no sub-module needed (optional ysyx_22050058_ifu_resp_hold for the output register set is not required).

## Test plan
- Reset: rst=1 two cycles with ce_i=1, mem_ack_i=1 → all outputs 0, mem_req_o=0, state IDLE.
- Basic fetch: pc_i=0x80000000, ce_i=1; ack 3 cycles after req with rdata=0x00000413 → mem_addr_o=0x80000000, stallreq_o high 2 cycles, inst_valid_o one cycle with inst_o=0x00000413, inst_pc_o=0x80000000.
- ID stall: ack with rdata=0x00100093 while stall_i=6'b000010 for 4 cycles → inst_valid_o held 5 cycles, inst_o unchanged; next fetch issued on cycle stall clears.
- Flush in flight: req for 0x80000004, flush_i pulse before ack, ack rdata=0xDEADBEEF → inst_valid_o stays 0; next accepted pc (jump target 0x80000100) fetched normally.
- Flush same cycle as ack, and flush in HOLD with stall_i[1]=1 → no/cleared valid, state IDLE next cycle.
- Misaligned: pc_i=0x80000006 → mem_addr_o=0x80000004, inst_misalign_o=1 with inst_pc_o=0x80000006.

Source files
------------

// File: rtl/ysyx_22050058_ifu_resp_pkg.sv
// rtl/ysyx_22050058_ifu_resp_pkg.sv - shared constants and state type for the IFU responder
// Contents:
//   ifu_state_t  - fetch FSM states (IDLE, REQ, HOLD)
//   CHIP_ENABLE  - ce_i value that requests a fetch
//   IS_JUMP      - flush_i value that marks a taken jump
//   STALL_ENABLE - stall vector bit value that holds a stage
//   STALL_IF_IDX - stall vector bit that holds the fetch stage
//   STALL_ID_IDX - stall vector bit that holds the ID stage
package ysyx_22050058_ifu_resp_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_HOLD = 2'd2
    } ifu_state_t;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic IS_JUMP      = 1'b1;
    localparam logic STALL_ENABLE = 1'b1;

    localparam int STALL_IF_IDX = 0;
    localparam int STALL_ID_IDX = 1;

endpackage

// File: rtl/ysyx_22050058_ifu_resp.sv
// rtl/ysyx_22050058_ifu_resp.sv - instruction-fetch responder between PC register, imem and ID
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   pc_i, ce_i          - fetch address and chip enable from the PC register
//   flush_i             - jump taken this cycle; kills the in-flight fetch/output
//   stall_i             - CtrlBlock stall vector ([0] holds IF, [1] holds ID)
//   mem_req_o/addr_o    - read request, held with a word-aligned address until ack
//   mem_ack_i/rdata_i   - read completion and data
//   inst_o, inst_pc_o   - fetched instruction and its PC to ID
//   inst_valid_o        - inst_o/inst_pc_o valid
//   inst_misalign_o     - fetched PC had nonzero low bits
//   stallreq_o          - combinational stall request while a fetch is pending
module ysyx_22050058_ifu_resp
    import ysyx_22050058_ifu_resp_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic              flush_i,
    input  logic [5:0]        stall_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [INST_W-1:0] mem_rdata_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    output logic              inst_misalign_o,
    output logic              stallreq_o
);

    ifu_state_t        state;
    logic [ADDR_W-1:0] pc_q;
    logic              misalign_q;
    // Set by a jump while the read is outstanding so the late data is thrown away.
    logic              drop;
    logic              accept;

    assign accept = (ce_i == CHIP_ENABLE) && (flush_i != IS_JUMP)
                 && (stall_i[STALL_IF_IDX] != STALL_ENABLE);

    assign stallreq_o = (state == IFU_REQ) && !mem_ack_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IFU_IDLE;
            mem_req_o       <= 1'b0;
            mem_addr_o      <= '0;
            pc_q            <= '0;
            misalign_q      <= 1'b0;
            drop            <= 1'b0;
            inst_o          <= '0;
            inst_pc_o       <= '0;
            inst_valid_o    <= 1'b0;
            inst_misalign_o <= 1'b0;
        end else begin
            case (state)
                IFU_IDLE: begin
                    inst_valid_o <= 1'b0;
                    if (accept) begin
                        pc_q       <= pc_i;
                        misalign_q <= |pc_i[1:0];
                        mem_addr_o <= {pc_i[ADDR_W-1:2], 2'b00};
                        mem_req_o  <= 1'b1;
                        state      <= IFU_REQ;
                    end
                end
                IFU_REQ: begin
                    if (flush_i == IS_JUMP) begin
                        drop <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        if (drop || (flush_i == IS_JUMP)) begin
                            drop         <= 1'b0;
                            inst_valid_o <= 1'b0;
                            state        <= IFU_IDLE;
                        end else begin
                            inst_o          <= mem_rdata_i;
                            inst_pc_o       <= pc_q;
                            inst_misalign_o <= misalign_q;
                            inst_valid_o    <= 1'b1;
                            state           <= IFU_HOLD;
                        end
                    end
                end
                IFU_HOLD: begin
                    // A jump overrides an ID stall: the held instruction is on the wrong path.
                    if (flush_i == IS_JUMP) begin
                        inst_valid_o <= 1'b0;
                        state        <= IFU_IDLE;
                    end else if (stall_i[STALL_ID_IDX] != STALL_ENABLE) begin
                        // ID takes the instruction this cycle; start the next fetch immediately.
                        inst_valid_o <= 1'b0;
                        if (accept) begin
                            pc_q       <= pc_i;
                            misalign_q <= |pc_i[1:0];
                            mem_addr_o <= {pc_i[ADDR_W-1:2], 2'b00};
                            mem_req_o  <= 1'b1;
                            state      <= IFU_REQ;
                        end else begin
                            state <= IFU_IDLE;
                        end
                    end
                end
                default: begin
                    mem_req_o    <= 1'b0;
                    inst_valid_o <= 1'b0;
                    state        <= IFU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050058_ifu_resp.sv
// tb/tb_ysyx_22050058_ifu_resp.sv - directed self-checking bench for ysyx_22050058_ifu_resp
module tb_ysyx_22050058_ifu_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_i;
    logic        ce_i;
    logic        flush_i;
    logic [5:0]  stall_i;
    logic        mem_req_o;
    logic [63:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] inst_o;
    logic [63:0] inst_pc_o;
    logic        inst_valid_o;
    logic        inst_misalign_o;
    logic        stallreq_o;

    int vecs = 0;
    int errs = 0;

    ysyx_22050058_ifu_resp #(.ADDR_W(64), .INST_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_i            (pc_i),
        .ce_i            (ce_i),
        .flush_i         (flush_i),
        .stall_i         (stall_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_ack_i       (mem_ack_i),
        .mem_rdata_i     (mem_rdata_i),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .inst_valid_o    (inst_valid_o),
        .inst_misalign_o (inst_misalign_o),
        .stallreq_o      (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; pc_i = 64'h8000_0000; ce_i = 1'b1; flush_i = 1'b0;
        stall_i = 6'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        tick(); tick();
        chk("rst_req", mem_req_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_pc", inst_pc_o, 0);
        chk("rst_valid", inst_valid_o, 0);
        chk("rst_mis", inst_misalign_o, 0);
        chk("rst_stallreq", stallreq_o, 0);
        rst = 1'b0; ce_i = 1'b0; mem_ack_i = 1'b0;
        tick();
        chk("idle_req", mem_req_o, 0);

        // basic fetch, ack on third request cycle
        pc_i = 64'h8000_0000; ce_i = 1'b1;
        tick(); ce_i = 1'b0;
        chk("bf_req", mem_req_o, 1);
        chk("bf_addr", mem_addr_o, 64'h8000_0000);
        chk("bf_stall1", stallreq_o, 1);
        tick();
        chk("bf_stall2", stallreq_o, 1);
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_0413; #1;
        chk("bf_stall_ack", stallreq_o, 0);
        tick(); mem_ack_i = 1'b0;
        chk("bf_valid", inst_valid_o, 1);
        chk("bf_inst", inst_o, 32'h0000_0413);
        chk("bf_pc", inst_pc_o, 64'h8000_0000);
        chk("bf_req_off", mem_req_o, 0);
        tick();
        chk("bf_valid_off", inst_valid_o, 0);

        // ID stall extends valid, back-to-back fetch on release
        pc_i = 64'h8000_0004; ce_i = 1'b1;
        tick(); ce_i = 1'b0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0010_0093;
        tick(); mem_ack_i = 1'b0; stall_i = 6'b000010;
        mem_rdata_i = 32'hAAAA_AAAA;
        chk("st_valid0", inst_valid_o, 1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("st_valid%0d", i), inst_valid_o, 1);
            chk($sformatf("st_inst%0d", i), inst_o, 32'h0010_0093);
        end
        stall_i = 6'b0; pc_i = 64'h8000_0008; ce_i = 1'b1;
        tick(); ce_i = 1'b0;
        chk("b2b_valid", inst_valid_o, 0);
        chk("b2b_req", mem_req_o, 1);
        chk("b2b_addr", mem_addr_o, 64'h8000_0008);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_0011;
        tick(); mem_ack_i = 1'b0;
        chk("b2b_inst", inst_o, 32'h0000_0011);
        chk("b2b_pc", inst_pc_o, 64'h8000_0008);
        tick();

        // flush while request outstanding
        pc_i = 64'h8000_0004; ce_i = 1'b1;
        tick(); ce_i = 1'b0; flush_i = 1'b1;
        tick(); flush_i = 1'b0;
        chk("fl_stallreq", stallreq_o, 1);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        tick(); mem_ack_i = 1'b0;
        chk("fl_valid", inst_valid_o, 0);
        chk("fl_req", mem_req_o, 0);
        chk("fl_stallreq_idle", stallreq_o, 0);
        pc_i = 64'h8000_0100; ce_i = 1'b1;
        tick(); ce_i = 1'b0;
        chk("jt_addr", mem_addr_o, 64'h8000_0100);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_0022;
        tick(); mem_ack_i = 1'b0;
        chk("jt_valid", inst_valid_o, 1);
        chk("jt_inst", inst_o, 32'h0000_0022);
        chk("jt_pc", inst_pc_o, 64'h8000_0100);
        tick();

        // flush in the ack cycle
        pc_i = 64'h8000_0200; ce_i = 1'b1;
        tick(); ce_i = 1'b0;
        mem_ack_i = 1'b1; flush_i = 1'b1; mem_rdata_i = 32'h0000_0055;
        tick(); flush_i = 1'b0;
        chk("fa_valid", inst_valid_o, 0);
        chk("fa_req", mem_req_o, 0);
        chk("fa_idle", stallreq_o, 0);
        tick(); mem_ack_i = 1'b0;
        chk("fa_stray_ack", inst_valid_o, 0);

        // flush in HOLD wins over ID stall
        pc_i = 64'h8000_0300; ce_i = 1'b1;
        tick(); ce_i = 1'b0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_0033;
        tick(); mem_ack_i = 1'b0;
        chk("fh_valid", inst_valid_o, 1);
        stall_i = 6'b000010; flush_i = 1'b1;
        tick(); flush_i = 1'b0; stall_i = 6'b0;
        chk("fh_cleared", inst_valid_o, 0);

        // misaligned fetch straight out of IDLE
        pc_i = 64'h8000_0006; ce_i = 1'b1;
        tick(); ce_i = 1'b0;
        chk("ma_req", mem_req_o, 1);
        chk("ma_addr", mem_addr_o, 64'h8000_0004);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_0044;
        tick(); mem_ack_i = 1'b0;
        chk("ma_valid", inst_valid_o, 1);
        chk("ma_flag", inst_misalign_o, 1);
        chk("ma_pc", inst_pc_o, 64'h8000_0006);
        tick();

        // flush or IF stall in IDLE blocks acceptance
        pc_i = 64'h8000_0400; ce_i = 1'b1; flush_i = 1'b1;
        tick(); flush_i = 1'b0;
        chk("fi_req", mem_req_o, 0);
        stall_i = 6'b000001;
        tick(); stall_i = 6'b0; ce_i = 1'b0;
        chk("si_req", mem_req_o, 0);

        // reset mid-request; a late ack must be ignored
        ce_i = 1'b1;
        tick(); ce_i = 1'b0;
        chk("rr_req", mem_req_o, 1);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("rr_req_off", mem_req_o, 0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_0066;
        tick(); mem_ack_i = 1'b0;
        chk("rr_valid", inst_valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
